// File: rtl/newhope_ct_mover.sv
// Copies a ciphertext from the encrypter output RAM into the decrypter input RAM,
// one byte per cycle, behind a one-cycle synchronous-read pipeline stage.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last transfer's results
// RUN   | issuing source reads 0..CT_BYTES-1, writing the previous read's byte
// DRAIN | last read issued; performs the final write
// DONE  | one-cycle completion pulse
module newhope_ct_mover #(
  parameter int CT_BYTES = 1088,
  parameter int DST_BASE = 0,
  parameter int AW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] src_addr,
  input  logic [7:0]    src_do,
  output logic [AW-1:0] dst_addra,
  output logic [7:0]    dst_dia,
  output logic          dst_wea,
  output logic [AW-1:0] xfer_count
);

  localparam longint LAST_DST = longint'(DST_BASE) + longint'(CT_BYTES) - 1;
  localparam longint ADDR_MAX = (longint'(1) << AW) - 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CT_BYTES - 1);
  localparam logic [AW-1:0] BASE      = AW'(DST_BASE);

  if (CT_BYTES < 2) begin : g_ct_too_small
    $error("newhope_ct_mover: CT_BYTES must be at least 2");
  end
  if (LAST_DST > ADDR_MAX) begin : g_dst_overflow
    $error("newhope_ct_mover: DST_BASE+CT_BYTES-1 exceeds the address range");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   src_addr_q, src_addr_d;
  logic [AW-1:0]   dst_addr_q, dst_addr_d;
  logic [AW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    count_d    = count_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          src_addr_d = '0;
          count_d    = '0;
          valid_d    = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          // The address sampled by the RAM this edge becomes next cycle's write.
          valid_d    = 1'b1;
          dst_addr_d = BASE + src_addr_q;
          if (valid_q) count_d = count_q + 1'b1;
          if (src_addr_q == LAST_ADDR) state_d = DRAIN;
          else src_addr_d = src_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        valid_d = 1'b0;
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (valid_q) count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign src_addr   = src_addr_q;
  assign dst_addra  = dst_addr_q;
  assign dst_dia    = src_do;
  assign dst_wea    = valid_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_newhope_ct_mover.sv
// Directed/randomized bench for newhope_ct_mover: a default instance and one with
// an offset destination, checked cycle by cycle against latency rules and a RAM model.
module tb_newhope_ct_mover;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic busy_a, done_a, wea_a, busy_b, done_b, wea_b;
  logic [AW-1:0] src_addr_a, addra_a, cnt_a, src_addr_b, addra_b, cnt_b;
  logic [7:0] src_do_a, dia_a, src_do_b, dia_b;

  newhope_ct_mover u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .src_addr(src_addr_a), .src_do(src_do_a),
    .dst_addra(addra_a), .dst_dia(dia_a), .dst_wea(wea_a), .xfer_count(cnt_a)
  );

  newhope_ct_mover #(.CT_BYTES(896), .DST_BASE(1088), .AW(AW)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .src_addr(src_addr_b), .src_do(src_do_b),
    .dst_addra(addra_b), .dst_dia(dia_b), .dst_wea(wea_b), .xfer_count(cnt_b)
  );

  always #5 clk = ~clk;

  logic [7:0] src_mem [0:2047];
  int         dst_mem [0:2047];
  int         wr_cnt;
  int         errors = 0;
  int         checks = 0;
  bit         sel = 1'b0;

  always @(posedge clk) begin
    src_do_a <= src_mem[src_addr_a];
    src_do_b <= src_mem[src_addr_b];
  end

  logic          obs_busy, obs_done, obs_wea;
  logic [AW-1:0] obs_src, obs_addra, obs_cnt;
  logic [7:0]    obs_dia;
  always_comb begin
    obs_busy  = sel ? busy_b : busy_a;
    obs_done  = sel ? done_b : done_a;
    obs_wea   = sel ? wea_b : wea_a;
    obs_src   = sel ? src_addr_b : src_addr_a;
    obs_addra = sel ? addra_b : addra_a;
    obs_cnt   = sel ? cnt_b : cnt_a;
    obs_dia   = sel ? dia_b : dia_a;
  end

  // Destination RAM model
  always @(posedge clk) begin
    if (obs_wea === 1'b1) begin
      dst_mem[obs_addra] = int'(obs_dia);
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic set_abort(input logic v);
    if (sel) abort_b = v; else abort_a = v;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(obs_busy), 0);
    chk({tag, "_done"}, 32'(obs_done), 0);
    chk({tag, "_wea"}, 32'(obs_wea), 0);
    chk({tag, "_src"}, 32'(obs_src), 0);
    chk({tag, "_addra"}, 32'(obs_addra), 0);
    chk({tag, "_cnt"}, 32'(obs_cnt), 0);
  endtask

  // Cycle k is the clock period that ends at edge k; start is sampled at edge 0.
  task automatic run(input bit inst, input int ct, input int base, input int abort_at,
                     input int rst_at, input int xs1, input int xs2, input bit start_with_abort);
    int exp_cnt, exp_wr, bad, wr_before;
    bit exp_busy, exp_wea, exp_done, cut;
    sel = inst;
    for (int i = 0; i < 2048; i++) dst_mem[i] = -1;
    wr_cnt = 0;
    @(negedge clk);
    set_start(1'b1);
    if (start_with_abort) set_abort(1'b1);
    @(posedge clk);
    for (int k = 1; k <= ct + 4; k++) begin
      @(negedge clk);
      set_start(1'b0);
      set_abort(1'b0);
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check_zero_outputs("rst_mid");
        wr_before = wr_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("post_rst_busy", 32'(obs_busy), 0);
          chk("post_rst_wea", 32'(obs_wea), 0);
        end
        chk("post_rst_writes", 32'(wr_cnt), 32'(wr_before));
        return;
      end
      cut = (abort_at > 0) && (k > abort_at);
      exp_busy = !cut && (k <= ct + 1);
      exp_wea  = !cut && (k >= 2) && (k <= ct + 1);
      exp_done = !cut && (k == ct + 2);
      if (cut) exp_cnt = (abort_at < 2) ? 0 : abort_at - 2;
      else     exp_cnt = (k < 2) ? 0 : ((k - 2 > ct) ? ct : k - 2);
      chk("busy", 32'(obs_busy), 32'(exp_busy));
      chk("wea", 32'(obs_wea), 32'(exp_wea));
      chk("done", 32'(obs_done), 32'(exp_done));
      chk("xfer_count", 32'(obs_cnt), 32'(exp_cnt));
      if (!cut && k <= ct) chk("src_addr", 32'(obs_src), 32'(k - 1));
      if (exp_wea) begin
        chk("dst_addra", 32'(obs_addra), 32'(base + k - 2));
        chk("dst_dia", 32'(obs_dia), 32'(src_mem[k - 2]));
      end
      if (k == xs1 || k == xs2) set_start(1'b1);
      if (k == abort_at) set_abort(1'b1);
      if (abort_at < 0 && k == ct + 2) set_abort(1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    set_abort(1'b0);
    set_start(1'b0);
    if (abort_at > 0) begin
      exp_wr = (abort_at < 2) ? 0 : abort_at - 1;
      chk("abort_writes", 32'(wr_cnt), 32'(exp_wr));
    end else begin
      chk("write_total", 32'(wr_cnt), 32'(ct));
      bad = 0;
      for (int a = 0; a < 2048; a++) begin
        if (a >= base && a < base + ct) begin
          if (dst_mem[a] != int'(src_mem[a - base])) bad++;
        end else if (dst_mem[a] != -1) bad++;
      end
      chk("mem_content", 32'(bad), 0);
    end
  endtask

  initial begin
    int ab;
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("rst_init");
    chk("rst_init_busy_b", 32'(busy_b), 0);
    chk("rst_init_wea_b", 32'(wea_b), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 2048; i++) src_mem[i] = 8'(i) ^ 8'h5A;
    run(0, 1088, 0, -1, -1, -1, -1, 1'b0);

    for (int i = 0; i < 2048; i++) src_mem[i] = 8'($urandom);
    run(0, 1088, 0, -1, -1, 10, 500, 1'b0);
    run(1, 896, 1088, -1, -1, 897, 898, 1'b1);

    run(0, 1088, 0, 100, -1, -1, -1, 1'b0);
    run(0, 1088, 0, -1, -1, -1, -1, 1'b0);

    for (int i = 0; i < 2048; i++) src_mem[i] = 8'($urandom);
    ab = int'($urandom_range(1, 1089));
    run(0, 1088, 0, ab, -1, -1, -1, 1'b0);
    run(0, 1088, 0, 1089, -1, -1, -1, 1'b0);

    run(0, 1088, 0, -1, 300, -1, -1, 1'b0);
    run(0, 1088, 0, -1, -1, -1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/newhope_ct_mover.md
NEWHOPE_CT_MOVER -- requirements
Module: newhope_ct_mover

Interface
REQ-001 SHALL have parameter CT_BYTES, default 1088: number of ciphertext bytes copied per transfer.
REQ-002 SHALL have parameter DST_BASE, default 0: destination address of the first byte written.
REQ-003 SHALL have parameter AW, default 11: width of the source and destination address buses.
REQ-004 SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have the remaining ports:
- start  in  1  one-cycle request to begin a transfer.
- abort  in  1  synchronous cancel of the transfer in progress.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse on normal completion.
- src_addr  out  AW  read address to the encrypter output RAM.
- src_do  in  8  read data from the encrypter output RAM, one-cycle latency.
- dst_addra  out  AW  write address to the decrypter input RAM.
- dst_dia  out  8  write data to the decrypter input RAM.
- dst_wea  out  1  write enable to the decrypter input RAM.
- xfer_count  out  AW  number of bytes written in the current or last transfer.

Function
REQ-006 SHALL implement a state machine with states IDLE, RUN, DRAIN and DONE.
REQ-007 In IDLE with start=1, the block SHALL move to RUN, drive src_addr=0 in the next cycle, and clear xfer_count to 0.
REQ-008 In IDLE, a cycle with start=0 SHALL leave the state and all outputs unchanged.
REQ-009 In RUN, the block SHALL increment src_addr by 1 each cycle (registered output), stepping through 0..CT_BYTES-1.
REQ-010 The block SHALL model the source RAM as a synchronous read: src_addr is sampled at a clock edge and src_do is valid in the following cycle.
REQ-011 A valid pipeline bit SHALL track each issued read, so that exactly one write occurs per issued address.
REQ-012 For a read issued at address a, the write in the next cycle SHALL drive:
- dst_wea=1,
- dst_addra=DST_BASE+a, registered,
- dst_dia=src_do, passed through combinationally.
REQ-013 When src_addr=CT_BYTES-1 is issued, the block SHALL move to DRAIN; DRAIN SHALL perform the final write and then move to DONE.
REQ-014 DONE SHALL last one cycle, during which done=1, busy=0 and dst_wea=0; the block SHALL then return to IDLE.
REQ-015 Latency: with start sampled at edge 0, writes SHALL occur in cycles 2..CT_BYTES+1 and done SHALL pulse in cycle CT_BYTES+2.
REQ-016 Throughput SHALL be one byte per cycle with no gaps between writes.
REQ-017 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE and DONE.
REQ-018 xfer_count SHALL increment by 1 on each write.
REQ-019 xfer_count SHALL equal CT_BYTES at done and SHALL hold that value until the next accepted start.
REQ-020 start while busy=1 or in DONE SHALL be ignored, with no effect on addresses or counts.
REQ-021 abort=1 in RUN or DRAIN SHALL:
- move the block to IDLE at the next edge,
- force dst_wea=0 from that edge onward,
- hold xfer_count at the number of writes already completed,
- suppress done.
REQ-022 abort=1 in IDLE or DONE SHALL be ignored.
REQ-023 If start and abort are both 1 in IDLE, start SHALL win.
REQ-024 Address arithmetic SHALL be modulo 2^AW; DST_BASE+CT_BYTES-1 SHALL not exceed 2^AW-1, and this SHALL be checked at elaboration.
REQ-025 CT_BYTES SHALL be at least 2.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE,
- busy=0, done=0, dst_wea=0,
- src_addr=0, dst_addra=0, xfer_count=0,
- the pipeline valid bit to 0.
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer, with no further writes after reset deasserts until a new start.
REQ-028 dst_dia SHALL follow src_do and is don't-care whenever dst_wea=0.

Verification
REQ-029 Reset values: assert rst with no clock edge → all outputs 0 and busy=0 within the same simulation time step.
REQ-030 Full transfer: source model with byte[a]=a[7:0]^8'h5A; pulse start at edge 0 → destination RAM addresses 0..1087 hold the pattern, done=1 only in cycle 1090, xfer_count=1088.
REQ-031 Offset destination: DST_BASE=1088, CT_BYTES=896 → writes land at 1088..1983, nothing is written outside that range, done in cycle 898.
REQ-032 Start while busy: pulse start again at cycles 10 and 500 → transfer is unchanged, exactly 1088 writes occur, single done pulse.
REQ-033 Abort: assert abort in cycle 100 → dst_wea=0 from cycle 101, xfer_count=98, no done; a new start then completes a full transfer.
REQ-034 Reset mid-transfer: assert rst in cycle 300 → outputs clear at once, no writes until the next start; the next start completes normally with done in cycle 1090 relative to that start.
